// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for the register RAM ports, with burst
// support and a starvation limit that only applies under contention.
module ram_arbiter #(
    parameter int unsigned D_WIDTH   = 19,
    parameter int unsigned A_WIDTH   = 5,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic               last0,
    input  logic               last1,
    input  logic [A_WIDTH-1:0] addr0,
    input  logic [A_WIDTH-1:0] addr1,
    input  logic [D_WIDTH-1:0] wdata0,
    input  logic [D_WIDTH-1:0] wdata1,
    output logic               gnt0,
    output logic               gnt1,
    output logic [D_WIDTH-1:0] rdata0,
    output logic [D_WIDTH-1:0] rdata1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [A_WIDTH-1:0] ram_address_write,
    output logic [D_WIDTH-1:0] ram_data_write,
    output logic               ram_write_enable,
    output logic [A_WIDTH-1:0] ram_address_read,
    input  logic [D_WIDTH-1:0] ram_data_read
);

    localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ptr;
    logic [CW-1:0] cnt;
    logic          beat0;
    logic          beat1;
    logic          own_req;
    logic          own_last;
    logic          other_req;
    logic          release_own;

    // RAM ports are decoded from state so a reset assertion blanks them at once
    always_comb begin
        beat0             = (state == OWN0) && req0;
        beat1             = (state == OWN1) && req1;
        ram_write_enable  = 1'b0;
        ram_address_write = '0;
        ram_address_read  = '0;
        ram_data_write    = '0;
        if (beat0) begin
            ram_write_enable  = we0;
            ram_address_write = addr0;
            ram_address_read  = addr0;
            ram_data_write    = wdata0;
        end else if (beat1) begin
            ram_write_enable  = we1;
            ram_address_write = addr1;
            ram_address_read  = addr1;
            ram_data_write    = wdata1;
        end
    end

    always_comb begin
        own_req     = (state == OWN0) ? req0  : req1;
        own_last    = (state == OWN0) ? last0 : last1;
        other_req   = (state == OWN0) ? req1  : req0;
        release_own = !own_req || own_last || ((cnt == CNT_MAX) && other_req);
        state_nxt   = state;
        case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = ptr ? OWN1 : OWN0;
                else if (req0)    state_nxt = OWN0;
                else if (req1)    state_nxt = OWN1;
            end
            OWN0: if (release_own) state_nxt = req1 ? OWN1 : IDLE;
            OWN1: if (release_own) state_nxt = req0 ? OWN0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            cnt     <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt0    <= (state_nxt == OWN0);
            gnt1    <= (state_nxt == OWN1);
            rvalid0 <= beat0 && !we0;
            rvalid1 <= beat1 && !we1;
            if (beat0 && !we0) rdata0 <= ram_data_read;
            if (beat1 && !we1) rdata1 <= ram_data_read;
            if ((state != IDLE) && release_own) ptr <= (state == OWN0);
            // cnt saturates so a lone requester can burst indefinitely
            if (state_nxt != state)  cnt <= '0;
            else if (state != IDLE && cnt != CNT_MAX) cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural RAM, reference memory and
// per-requester read scoreboards checked with immediate assertions.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1, last0, last1;
    logic [4:0]  addr0, addr1;
    logic [18:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [18:0] rdata0, rdata1;
    logic [4:0]  ram_address_write, ram_address_read;
    logic [18:0] ram_data_write, ram_data_read;
    logic        ram_write_enable;

    logic [18:0] mem     [32];
    logic [18:0] ref_mem [32];
    logic [18:0] q0 [$];
    logic [18:0] q1 [$];
    logic        pend0, pend1;
    int          total, bad;

    ram_arbiter #(.D_WIDTH(19), .A_WIDTH(5), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .last0(last0), .last1(last1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .ram_address_write(ram_address_write), .ram_data_write(ram_data_write),
        .ram_write_enable(ram_write_enable), .ram_address_read(ram_address_read),
        .ram_data_read(ram_data_read)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_write_enable) mem[ram_address_write] <= ram_data_write;
    assign ram_data_read = mem[ram_address_read];

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic r, input logic w, input logic l,
                        input logic [4:0] a, input logic [18:0] d);
        req0 = r; we0 = w; last0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic l,
                        input logic [4:0] a, input logic [18:0] d);
        req1 = r; we1 = w; last1 = l; addr1 = a; wdata1 = d;
    endtask

    // One cycle: inputs are already driven; check at negedge, then step past posedge.
    task automatic cyc(input logic eg0, input logic eg1);
        logic        b0, b1;
        logic [18:0] e;
        @(negedge clk);
        chk("rvalid0", {18'd0, rvalid0}, {18'd0, pend0});
        chk("rvalid1", {18'd0, rvalid1}, {18'd0, pend1});
        if (pend0) begin e = q0.pop_front(); chk("rdata0", rdata0, e); end
        if (pend1) begin e = q1.pop_front(); chk("rdata1", rdata1, e); end
        chk("gnt0", {18'd0, gnt0}, {18'd0, eg0});
        chk("gnt1", {18'd0, gnt1}, {18'd0, eg1});
        b0 = eg0 && req0;
        b1 = eg1 && req1;
        chk("ram_we", {18'd0, ram_write_enable}, {18'd0, (b0 && we0) || (b1 && we1)});
        if (b0 || b1 || !(eg0 || eg1)) begin
            chk("ram_raddr", {14'd0, ram_address_read},
                {14'd0, b0 ? addr0 : (b1 ? addr1 : 5'd0)});
            chk("ram_waddr", {14'd0, ram_address_write},
                {14'd0, b0 ? addr0 : (b1 ? addr1 : 5'd0)});
            chk("ram_wdata", ram_data_write, b0 ? wdata0 : (b1 ? wdata1 : 19'd0));
        end
        pend0 = b0 && !we0;
        pend1 = b1 && !we1;
        if (pend0) q0.push_back(ref_mem[addr0]);
        if (pend1) q1.push_back(ref_mem[addr1]);
        if (b0 && we0) ref_mem[addr0] = wdata0;
        if (b1 && we1) ref_mem[addr1] = wdata1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beats;
        clk = 1'b0; reset = 1'b0; total = 0; bad = 0; pend0 = 1'b0; pend1 = 1'b0;
        for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        drv0(0, 0, 0, '0, '0);
        drv1(0, 0, 0, '0, '0);
        #1;
        chk("rst_gnt0", {18'd0, gnt0}, '0);
        chk("rst_gnt1", {18'd0, gnt1}, '0);
        chk("rst_rvalid", {17'd0, rvalid1, rvalid0}, '0);
        chk("rst_rdata0", rdata0, '0);
        chk("rst_rdata1", rdata1, '0);
        chk("rst_we", {18'd0, ram_write_enable}, '0);
        @(posedge clk); #1;
        reset = 1'b1;

        // idle: no grants, no writes
        for (int i = 0; i < 10; i++) cyc(0, 0);

        // single write then read back
        drv0(1, 1, 1, 5'd3, 19'h1ABCD); cyc(0, 0); cyc(1, 0);
        drv0(1, 0, 1, 5'd3, '0);        cyc(0, 0); cyc(1, 0);
        drv0(0, 0, 0, '0, '0);          cyc(0, 0);

        // write then read same address on the next beat
        drv0(1, 1, 0, 5'd10, 19'h055AA); cyc(0, 0); cyc(1, 0);
        drv0(1, 0, 1, 5'd10, '0);        cyc(1, 0);
        drv0(0, 0, 0, '0, '0);           cyc(0, 0);

        // lone requester runs past MAX_BURST without losing the grant
        drv0(1, 0, 0, 5'd0, '0); cyc(0, 0);
        for (int i = 0; i < 12; i++) begin
            drv0(1, 0, (i == 11), 5'(i), '0);
            cyc(1, 0);
        end
        drv0(0, 0, 0, '0, '0); cyc(0, 0);

        // async reset in the middle of an OWN0 write burst
        drv0(1, 1, 0, 5'd5, 19'h2468A); cyc(0, 0); cyc(1, 0);
        drv0(1, 1, 0, 5'd6, 19'h13579);
        #2;
        chk("mid_gnt0", {18'd0, gnt0}, 19'd1);
        chk("mid_we", {18'd0, ram_write_enable}, 19'd1);
        reset = 1'b0;
        #1;
        chk("arst_gnt0", {18'd0, gnt0}, '0);
        chk("arst_gnt1", {18'd0, gnt1}, '0);
        chk("arst_we", {18'd0, ram_write_enable}, '0);
        chk("arst_rvalid", {17'd0, rvalid1, rvalid0}, '0);
        drv0(0, 0, 0, '0, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        pend0 = 1'b0; pend1 = 1'b0;
        q0.delete(); q1.delete();
        chk("post_rdata0", rdata0, '0);

        // simultaneous single-beat reads: 0, 1, 0 again with no bubble
        drv0(1, 0, 1, 5'd5, '0);
        drv1(1, 0, 1, 5'd3, '0);
        cyc(0, 0); cyc(1, 0); cyc(0, 1); cyc(1, 0);
        drv0(0, 0, 0, '0, '0);
        drv1(0, 0, 0, '0, '0);
        cyc(0, 1); cyc(0, 0);

        // starvation limit: 8 beats for req0, then one cycle for req1
        drv1(1, 0, 1, 5'd10, '0);
        drv0(1, 0, 0, 5'd0, '0);
        cyc(0, 0);
        beats = 0;
        while (beats < 20) begin
            for (int k = 0; k < 8 && beats < 20; k++) begin
                drv0(1, 0, 0, 5'(beats), '0);
                cyc(1, 0);
                beats++;
            end
            if (beats < 20) cyc(0, 1);
        end
        drv0(0, 0, 0, '0, '0);
        cyc(1, 0); cyc(0, 1);
        drv1(0, 0, 0, '0, '0);
        cyc(0, 0);

        // abandon: granted req1 drops with no beat
        drv1(1, 0, 1, 5'd2, '0); cyc(0, 0);
        drv1(0, 1, 0, 5'd2, 19'h7FFFF); cyc(0, 1);
        drv1(0, 0, 0, '0, '0); cyc(0, 0); cyc(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
